// File: rtl/regfile_cc_pkg.sv
// regfile_cc_pkg: shared encodings for the LC-3b register file / CC unit.
//   - REG_R0..REG_R7 register select encodings
//   - CC_N/CC_Z/CC_P bit positions inside the {n,z,p} vector
//   - CC_RESET value of {n,z,p} after reset
//   - SR2MUX_REG / SR2MUX_IMM select values for the ALU B operand mux
//   - sext5(): sign-extend the imm5 field to the data width
package regfile_cc_pkg;

    localparam int DATA_W = 16;

    localparam logic [2:0] REG_R0 = 3'd0;
    localparam logic [2:0] REG_R1 = 3'd1;
    localparam logic [2:0] REG_R2 = 3'd2;
    localparam logic [2:0] REG_R3 = 3'd3;
    localparam logic [2:0] REG_R4 = 3'd4;
    localparam logic [2:0] REG_R5 = 3'd5;
    localparam logic [2:0] REG_R6 = 3'd6;
    localparam logic [2:0] REG_R7 = 3'd7;

    localparam int CC_N = 2;
    localparam int CC_Z = 1;
    localparam int CC_P = 0;

    localparam logic [2:0] CC_RESET = 3'b010;

    localparam logic SR2MUX_REG = 1'b0;
    localparam logic SR2MUX_IMM = 1'b1;

    function automatic logic [DATA_W-1:0] sext5(input logic [4:0] imm);
        return {{(DATA_W-5){imm[4]}}, imm};
    endfunction

endpackage

// File: rtl/regfile_cc_cc_logic.sv
// cc_logic: purely combinational N/Z/P flag generation from a data value.
// Ports:
//   i_val  [WIDTH-1:0]  value to classify (two's complement)
//   o_nzp  [2:0]        {n,z,p}; exactly one bit is set
module cc_logic
    import regfile_cc_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] i_val,
    output logic [2:0]       o_nzp
);

    logic w_neg;
    logic w_nonzero;

    assign w_neg     = i_val[WIDTH-1];
    assign w_nonzero = |i_val;

    always_comb begin
        o_nzp       = 3'b000;
        o_nzp[CC_N] = w_neg;
        o_nzp[CC_Z] = ~w_nonzero;
        o_nzp[CC_P] = ~w_neg & w_nonzero;
    end

endmodule

// File: rtl/regfile_cc.sv
// regfile_cc: LC-3b general-purpose register file plus condition-code unit.
// Optional feature macro: REGFILE_BYPASS_EN (write-through forwarding of bus_in
// to the read ports when the read select matches the register being written).
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   bus_in            processor bus value captured into R[dr] / flags
//   ld_reg, dr        register write enable and destination select
//   ld_cc             load {n,z,p} from bus_in
//   sr1, sr2          read selects (ALU A / ALU B)
//   sr2mux_sel, imm5  B operand select: register or sign-extended imm5
//   sr1_out, sr2_out  ALU operands (combinational reads)
//   n, z, p           condition-code flags
module regfile_cc
    import regfile_cc_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NREGS = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         bus_in,
    input  logic                     ld_reg,
    input  logic [$clog2(NREGS)-1:0] dr,
    input  logic                     ld_cc,
    input  logic [$clog2(NREGS)-1:0] sr1,
    input  logic [$clog2(NREGS)-1:0] sr2,
    input  logic                     sr2mux_sel,
    input  logic [4:0]               imm5,
    output logic [WIDTH-1:0]         sr1_out,
    output logic [WIDTH-1:0]         sr2_out,
    output logic                     n,
    output logic                     z,
    output logic                     p
);

    logic [NREGS-1:0][WIDTH-1:0] r_regs;
    logic [2:0]                  r_nzp;
    logic [2:0]                  w_nzp_next;
    logic [WIDTH-1:0]            w_rd1;
    logic [WIDTH-1:0]            w_rd2;
    logic [WIDTH-1:0]            w_imm;

    cc_logic #(.WIDTH(WIDTH)) u_cc (
        .i_val (bus_in),
        .o_nzp (w_nzp_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_regs <= '0;
        end else if (ld_reg) begin
            r_regs[dr] <= bus_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_nzp <= CC_RESET;
        end else if (ld_cc) begin
            r_nzp <= w_nzp_next;
        end
    end

`ifdef REGFILE_BYPASS_EN
    // Forward the value being written so a same-cycle consumer sees it.
    assign w_rd1 = (ld_reg && sr1 == dr) ? bus_in : r_regs[sr1];
    assign w_rd2 = (ld_reg && sr2 == dr) ? bus_in : r_regs[sr2];
`else
    assign w_rd1 = r_regs[sr1];
    assign w_rd2 = r_regs[sr2];
`endif

    assign w_imm   = {{(WIDTH-5){imm5[4]}}, imm5};
    assign sr1_out = w_rd1;
    assign sr2_out = (sr2mux_sel == SR2MUX_IMM) ? w_imm : w_rd2;

    assign n = r_nzp[CC_N];
    assign z = r_nzp[CC_Z];
    assign p = r_nzp[CC_P];

endmodule

// File: tb/tb_regfile_cc.sv
module tb_regfile_cc;

    logic        clk;
    logic        rst;
    logic [15:0] bus_in;
    logic        ld_reg;
    logic [2:0]  dr;
    logic        ld_cc;
    logic [2:0]  sr1;
    logic [2:0]  sr2;
    logic        sr2mux_sel;
    logic [4:0]  imm5;
    logic [15:0] sr1_out;
    logic [15:0] sr2_out;
    logic        n, z, p;

    int n_vec = 0;
    int n_err = 0;

    regfile_cc #(.WIDTH(16), .NREGS(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus_in     (bus_in),
        .ld_reg     (ld_reg),
        .dr         (dr),
        .ld_cc      (ld_cc),
        .sr1        (sr1),
        .sr2        (sr2),
        .sr2mux_sel (sr2mux_sel),
        .imm5       (imm5),
        .sr1_out    (sr1_out),
        .sr2_out    (sr2_out),
        .n          (n),
        .z          (z),
        .p          (p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] cc_bus [3];
    logic [2:0]  cc_exp [3];
    logic [15:0] e;

    initial begin
        cc_bus[0] = 16'h8000; cc_exp[0] = 3'b100;
        cc_bus[1] = 16'h0000; cc_exp[1] = 3'b010;
        cc_bus[2] = 16'h0579; cc_exp[2] = 3'b001;

        rst = 1'b1; bus_in = '0; ld_reg = 1'b0; dr = '0; ld_cc = 1'b0;
        sr1 = '0; sr2 = '0; sr2mux_sel = 1'b0; imm5 = '0;
        repeat (2) step();
        chk("rst_sr1", sr1_out, 16'h0000);
        chk("rst_sr2", sr2_out, 16'h0000);
        chk("rst_nzp", {13'd0, n, z, p}, 16'h0002);
        rst = 1'b0;
        step();

        // Write R0..R7 on consecutive edges, then read back every register.
        for (int i = 0; i < 8; i++) begin
            ld_reg = 1'b1; dr = 3'(i); bus_in = 16'(16'h1111 * (i + 1));
            step();
        end
        ld_reg = 1'b0;
        for (int i = 0; i < 8; i++) begin
            sr1 = 3'(i); sr2 = 3'(7 - i); #1;
            e = 16'(16'h1111 * (i + 1));
            chk($sformatf("rd_sr1_r%0d", i), sr1_out, e);
            e = 16'(16'h1111 * (8 - i));
            chk($sformatf("rd_sr2_r%0d", 7 - i), sr2_out, e);
        end
        sr1 = 3'd4; sr2 = 3'd4; #1;
        chk("same_sel_sr1", sr1_out, 16'h5555);
        chk("same_sel_sr2", sr2_out, 16'h5555);

        // Condition codes from ld_cc alone.
        for (int i = 0; i < 3; i++) begin
            ld_cc = 1'b1; bus_in = cc_bus[i];
            step();
            chk($sformatf("cc_%h", cc_bus[i]), {13'd0, n, z, p}, {13'd0, cc_exp[i]});
        end
        ld_cc = 1'b0; bus_in = 16'hFFFF;
        step();
        chk("cc_hold", {13'd0, n, z, p}, 16'h0001);
        sr1 = 3'd0; #1;
        chk("cc_only_regs", sr1_out, 16'h1111);

        // SR2MUX.
        sr2mux_sel = 1'b1; imm5 = 5'b01111; #1;
        chk("imm_pos", sr2_out, 16'h000F);
        imm5 = 5'b10000; #1;
        chk("imm_neg", sr2_out, 16'hFFF0);
        sr2mux_sel = 1'b0; sr2 = 3'd5; #1;
        chk("sr2_reg5", sr2_out, 16'h6666);

        // ALU loop: R4 = R1 + R2 with flag update.
        ld_reg = 1'b1; dr = 3'd1; bus_in = 16'h0001; step();
        dr = 3'd2; bus_in = 16'h0002; step();
        ld_reg = 1'b0; sr1 = 3'd1; sr2 = 3'd2; #1;
        bus_in = sr1_out + sr2_out;
        ld_reg = 1'b1; ld_cc = 1'b1; dr = 3'd4;
        step();
        ld_reg = 1'b0; ld_cc = 1'b0; sr1 = 3'd4; #1;
        chk("alu_r4", sr1_out, 16'h0003);
        chk("alu_nzp", {13'd0, n, z, p}, 16'h0001);

        // Read during write on R6.
        ld_reg = 1'b1; dr = 3'd6; bus_in = 16'h0007; step();
        sr1 = 3'd6; bus_in = 16'hDEAD; #1;
`ifdef REGFILE_BYPASS_EN
        chk("rdw_before", sr1_out, 16'hDEAD);
`else
        chk("rdw_before", sr1_out, 16'h0007);
`endif
        step();
        ld_reg = 1'b0; #1;
        chk("rdw_after", sr1_out, 16'hDEAD);

        // Asynchronous reset in the middle of a write + flag load.
        ld_reg = 1'b1; ld_cc = 1'b1; dr = 3'd3; bus_in = 16'h8000; step();
        sr1 = 3'd3; #1;
        chk("pre_rst_r3", sr1_out, 16'h8000);
        chk("pre_rst_nzp", {13'd0, n, z, p}, 16'h0004);
        bus_in = 16'hBEEF;
        @(negedge clk); #2;
        rst = 1'b1; #1;
        chk("arst_r3", sr1_out, 16'h0000);
        chk("arst_nzp", {13'd0, n, z, p}, 16'h0002);
        step();
        chk("arst_edge_r3", sr1_out, 16'h0000);
        rst = 1'b0; ld_reg = 1'b0; ld_cc = 1'b0;
        step();
        chk("post_rst_r3", sr1_out, 16'h0000);
        sr1 = 3'd7; #1;
        chk("post_rst_r7", sr1_out, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_cc.md
Name: regfile_cc

Overview:
- LC-3b general-purpose register file plus condition-code unit, directly upstream and downstream of the ALU.
- Feeds the ALU A input (SR1) and B input (SR2, or sign-extended imm5 through SR2MUX).
- Captures the processor bus (ALU result when gate_alu is high) into destination register DR.
- Updates the N/Z/P flags from the same bus value.

Parameters:
- WIDTH, 16, data width of registers, bus and ALU operands
- NREGS, 8, number of general-purpose registers (R0–R7); register selects are clog2(NREGS)=3 bits

Ports:
- clk  input  1  system clock; all state changes on rising edge
- rst  input  1  asynchronous, active-high reset
- bus_in  input  WIDTH  processor bus value (ALU out when gated)
- ld_reg  input  1  write enable for register DR
- dr  input  3  destination register select
- ld_cc  input  1  load N/Z/P from bus_in
- sr1  input  3  source register 1 select (drives ALU A)
- sr2  input  3  source register 2 select
- sr2mux_sel  input  1  0: B = R[sr2]; 1: B = sext(imm5)
- imm5  input  5  immediate field from IR[4:0]
- sr1_out  output  WIDTH  ALU A operand
- sr2_out  output  WIDTH  ALU B operand
- n  output  1  negative flag
- z  output  1  zero flag
- p  output  1  positive flag

Behaviour:
- Reset (asynchronous, effective immediately when rst rises, including mid-write):
  - R0–R7 = 16'h0000.
  - {n,z,p} = 3'b010.
  - sr1_out and sr2_out therefore read 0 (or sext(imm5) when sr2mux_sel=1).
- Reset dominates ld_reg and ld_cc on the same edge; no write occurs.
- Reads are combinational, zero latency:
  - sr1_out = R[sr1].
  - sr2_out = sr2mux_sel ? {{11{imm5[4]}}, imm5} : R[sr2].
- Write: on rising clk with ld_reg=1, R[dr] <= bus_in. Visible on read ports after the edge. ld_reg=0 means no change.
- CC: on rising clk with ld_cc=1:
  - n = bus_in[15].
  - z = (bus_in == 0).
  - p = !bus_in[15] && (bus_in != 0).
  - Exactly one flag is high at all times.
- ld_reg and ld_cc together: both update from the same bus_in on the same edge (normal ALU-op writeback).
- ld_cc alone: flags update, registers unchanged.
- sr1 == sr2: both ports return the same value. sr1 == dr during a write: the port returns the old value until the edge (unless BYPASS, below).
- All arithmetic is width-exact; no wrap logic. Sign extension of imm5 covers -16..+15, e.g. 5'b10000 -> 16'hFFF0.
- R0 is an ordinary writable register (LC-3b has no hardwired zero).
- X/Z on select inputs while the corresponding enable is low has no effect on state.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-through forwarding.
  - If ld_reg=1 and sr1==dr, sr1_out = bus_in combinationally during that cycle.
  - Same for sr2 when sr2mux_sel=0.
  - Lets a same-cycle consumer see the value being written.
- Undefined: no forwarding; reads always return stored register contents. The default microsequencer timing does not rely on bypass.

Decomposition:
- Shared header regfile.vh (alongside alu.vh) holds:
  - `REG_R0..`REG_R7 encodings
  - `CC_N/`CC_Z/`CC_P bit positions
  - `CC_RESET (3'b010)
  - `SR2MUX_REG / `SR2MUX_IMM select values
- One sub-module: cc_logic.
  - Purely combinational: WIDTH-bit value -> {n,z,p}.
  - Instanced on bus_in; its output is registered in regfile_cc.
  - Reusable by later load-path flag logic.

Test Plan:
- Reset: assert rst mid-cycle with ld_reg=1, dr=3, bus_in=16'hBEEF -> immediately R3=0, {n,z,p}=010; after release, sr1=3 reads 16'h0000.
- Write/read all: write R0..R7 = 16'h1111*(i+1) on consecutive edges -> each sr1/sr2 read returns the written value; unselected registers unchanged.
- CC: ld_cc with bus_in = 16'h8000 -> 100; 16'h0000 -> 010; 16'h0579 -> 001; ld_cc=0 with bus_in=16'hFFFF -> flags hold.
- SR2MUX: sr2mux_sel=1, imm5=5'b01111 -> sr2_out=16'h000F; imm5=5'b10000 -> 16'hFFF0; sel=0, sr2=5 -> R5.
- ALU loop: R1=1, R2=2; sr1=1, sr2=2, ALU ADD, gate_alu=1, ld_reg=1, dr=4, ld_cc=1 -> after edge R4=16'h0003, flags 001.
- Same-cycle read-during-write: sr1=dr=6, ld_reg=1, bus_in=16'hDEAD, R6 previously 16'h0007 -> sr1_out=16'h0007 before the edge without REGFILE_BYPASS_EN, 16'hDEAD with it; 16'hDEAD after the edge in both builds.
